// File: rtl/mem_access_unit.sv
// mem_access_unit
//   RV32I load/store initiator for a word-wide RAM without byte enables.
//   One request at a time; sub-word stores use read-modify-write, loads are
//   lane-extracted and sign/zero-extended, bad requests get an error response
//   without touching memory.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   req_valid/req_ready           request handshake; ready only while idle
//   req_we, req_funct3            store/load select and RV32I width code
//   req_addr, req_wdata           byte address and right-aligned store data
//   resp_valid                    one-cycle completion pulse
//   resp_rdata, resp_err          registered response, held until the next one
//   mem_ren, mem_raddr            RAM read port (data returns next cycle)
//   mem_wen, mem_waddr, mem_wdata RAM write port
//   mem_rdata                     RAM read data
module mem_access_unit #(
  parameter  int MEM_WIDTH  = 32,
  parameter  int MEM_DEPTH  = 256,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [MEM_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  output logic [MEM_WIDTH-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  input  logic [MEM_WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_MERGE, S_WRITE} state_t;

  state_t state, state_d;

  logic                  we_p0;
  logic [2:0]            f3_p0;
  logic [ADDR_WIDTH+1:0] addr_p0;
  logic [MEM_WIDTH-1:0]  word_p1;

  logic                  accept;
  logic                  merge_en;
  logic                  resp_valid_d;
  logic                  resp_err_d;
  logic [MEM_WIDTH-1:0]  resp_rdata_d;

  // Addresses wrap modulo the RAM size; the upper bits are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a != 2'b00;
      3'b100:  return we;            // no unsigned store
      3'b101:  return we | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [MEM_WIDTH-1:0] load_extract(input logic [2:0] f3,
      input logic [1:0] a, input logic [MEM_WIDTH-1:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = rdata[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return MEM_WIDTH'(b);
      3'b100:  return MEM_WIDTH'(unsigned'(b));
      3'b001:  return MEM_WIDTH'(h);
      3'b101:  return MEM_WIDTH'(unsigned'(h));
      default: return rdata;
    endcase
  endfunction

  function automatic logic [MEM_WIDTH-1:0] store_merge(input logic [2:0] f3,
      input logic [1:0] a, input logic [MEM_WIDTH-1:0] old,
      input logic [MEM_WIDTH-1:0] wd);
    logic [MEM_WIDTH-1:0] w;
    w = old;
    if (f3 == 3'b000) w[{a, 3'b000} +: 8] = wd[7:0];
    else              w[{a[1], 4'b0000} +: 16] = wd[15:0];
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  // p0: request capture; p1: store word, overwritten by the merged word in MERGE
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0   <= req_we;
      f3_p0   <= req_funct3;
      addr_p0 <= req_addr[ADDR_WIDTH+1:0];
      word_p1 <= req_wdata;
    end else if (merge_en) begin
      word_p1 <= store_merge(f3_p0, addr_p0[1:0], mem_rdata, word_p1);
    end
  end

  always_comb begin
    state_d      = state;
    accept       = 1'b0;
    merge_en     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err;
    resp_rdata_d = resp_rdata;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_error(req_we, req_funct3, req_addr[1:0])) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we && req_funct3 == 3'b010) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_MERGE;
      S_MERGE: begin
        if (we_p0) begin
          merge_en = 1'b1;
          state_d  = S_WRITE;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_extract(f3_p0, addr_p0[1:0], mem_rdata);
          state_d      = S_IDLE;
        end
      end
      S_WRITE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign mem_ren   = (state == S_READ);
  // A reset landing on the WRITE cycle must not corrupt memory.
  assign mem_wen   = (state == S_WRITE) && !rst;
  assign mem_raddr = addr_p0[ADDR_WIDTH+1:2];
  assign mem_waddr = addr_p0[ADDR_WIDTH+1:2];
  assign mem_wdata = word_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic [7:0]  mem_raddr;
  logic        mem_wen;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit #(.MEM_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, synchronous write
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ram[mem_raddr];
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  int overlap = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every response pulse
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mem_ren) ren_cnt++;
    if (mem_wen) wen_cnt++;
    if (mem_ren && mem_wen) overlap++;
    if (resp_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response",
                 resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err || (cyc - e.acc) != e.lat) begin
          fails++;
          $display("FAIL resp: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                   resp_rdata, resp_err, cyc - e.acc, e.rdata, e.err, e.lat);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns just after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input bit track);
    int t = 0;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (track) begin
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = lat;
        e.acc   = cyc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    req_valid = 1'b0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [31:0] exp_rdata,
                    input logic exp_err, input int lat);
    issue(we, f3, addr, wdata, exp_rdata, exp_err, lat, 1'b1);
    drain();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  {31'b0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_resp_err"},   {31'b0, resp_err},   32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
    check({tag, "_mem_ren"},    {31'b0, mem_ren},    32'd0);
    check({tag, "_mem_wen"},    {31'b0, mem_wen},    32'd0);
  endtask

  initial begin
    int r0, w0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Word store then load
    w0 = wen_cnt;
    op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    check("sw_wen_count", wen_cnt - w0, 1);
    check("sw_ram_word4", ram[4], 32'hDEADBEEF);
    op(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Sub-word read-modify-write
    op(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 1);
    r0 = ren_cnt; w0 = wen_cnt;
    op(1'b1, 3'b000, 32'h12, 32'h000000AA, 32'h0, 1'b0, 3);
    check("sb_ren_count", ren_cnt - r0, 1);
    check("sb_wen_count", wen_cnt - w0, 1);
    check("sb_ram_word4", ram[4], 32'h11AA3344);
    r0 = ren_cnt; w0 = wen_cnt;
    op(1'b1, 3'b001, 32'h10, 32'h0000BEEF, 32'h0, 1'b0, 3);
    check("sh_ren_count", ren_cnt - r0, 1);
    check("sh_wen_count", wen_cnt - w0, 1);
    op(1'b0, 3'b010, 32'h10, 32'h0, 32'h11AABEEF, 1'b0, 2);

    // Extension
    op(1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 1);
    op(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    op(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    op(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    op(1'b0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2);

    // Errors, back-to-back on consecutive edges
    r0 = ren_cnt; w0 = wen_cnt;
    issue(1'b0, 3'b010, 32'h11, 32'h0,      32'h0, 1'b1, 0, 1'b1);
    issue(1'b1, 3'b001, 32'h13, 32'h5555,   32'h0, 1'b1, 0, 1'b1);
    issue(1'b0, 3'b011, 32'h10, 32'h0,      32'h0, 1'b1, 0, 1'b1);
    issue(1'b1, 3'b100, 32'h10, 32'h77,     32'h0, 1'b1, 0, 1'b1);
    drain();
    check("err_ren_count", ren_cnt - r0, 0);
    check("err_wen_count", wen_cnt - w0, 0);
    check("err_ram_word4", ram[4], 32'h80FF7F01);

    // Address wrap
    op(1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0, 1'b0, 1);
    check("wrap_ram_word0", ram[0], 32'h12345678);
    op(1'b0, 3'b010, 32'h0, 32'h0, 32'h12345678, 1'b0, 2);

    // Back-to-back with req_valid held high
    issue(1'b1, 3'b010, 32'h20, 32'h00000001, 32'h0,        1'b0, 1, 1'b1);
    issue(1'b1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0,        1'b0, 1, 1'b1);
    issue(1'b0, 3'b010, 32'h20, 32'h0,        32'h00000001, 1'b0, 2, 1'b1);
    issue(1'b1, 3'b000, 32'h25, 32'h0000005A, 32'h0,        1'b0, 3, 1'b1);
    issue(1'b0, 3'b100, 32'h25, 32'h0,        32'h0000005A, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b001, 32'h26, 32'h0,        32'hFFFFCAFE, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h22, 32'h0,        32'h0,        1'b1, 0, 1'b1);
    issue(1'b1, 3'b001, 32'h22, 32'h00001234, 32'h0,        1'b0, 3, 1'b1);
    issue(1'b0, 3'b010, 32'h20, 32'h0,        32'h12340001, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b101, 32'h26, 32'h0,        32'h0000CAFE, 1'b0, 2, 1'b1);
    drain();
    check("b2b_ram_word9", ram[9], 32'hCAFE5A0D);

    // Reset during the WRITE cycle of a byte store
    op(1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0, 1'b0, 1);
    w0 = wen_cnt;
    issue(1'b1, 3'b000, 32'h30, 32'h000000EE, 32'h0, 1'b0, 0, 1'b0);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_write_mem_wen", {31'b0, mem_wen}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_write");
    repeat (4) @(negedge clk);
    check("rst_write_wen_count", wen_cnt - w0, 0);
    check("rst_write_ram_word12", ram[12], 32'h11111111);

    // Reset during READ of a load
    issue(1'b0, 3'b010, 32'h24, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("rst_read");

    // Normal operation resumes
    op(1'b0, 3'b010, 32'h24, 32'h0, 32'hCAFE5A0D, 1'b0, 2);

    check("rw_overlap_cycles", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
